conv_encoder: RTL and testbench

Rate-1/2 feed-forward convolutional encoder with zero-tail frame termination, sitting directly downstream of the PN/M-sequence test source in the coding chain. It consumes one information bit per accepted transfer and produces one 2-bit codeword per output transfer. After every FRAME_LEN data bits it autonomously appends K-1 zero tail bits, so every frame ends with the encoder back in the all-zero state for the downstream Viterbi decoder. Valid/ready handshakes on both sides allow the decoder or channel model to stall it.

---
 rtl/conv_encoder.sv | 123 ++++++++++++
 tb/tb_conv_encoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with zero-tail frame termination.
// One information bit in, one registered {c0,c1} codeword out, valid/ready on both sides.
module conv_encoder #(
    parameter int             K         = 3,
    parameter logic [K-1:0]   G0        = 3'b111,
    parameter logic [K-1:0]   G1        = 3'b101,
    parameter int             FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] out_bits,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);

    localparam int DCNT_W = $clog2(FRAME_LEN + 1);
    localparam int TCNT_W = $clog2(K);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(FRAME_LEN - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(K - 2);

    typedef enum logic {
        S_DATA = 1'b0,
        S_TAIL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [K-2:0]        sr_q, sr_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [1:0]          out_bits_q, out_bits_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;

    logic                win_bit;
    logic [K-1:0]        win;
    logic                c0, c1;
    logic                out_free;
    logic                in_ready_c;
    logic                load;

    // Datapath: the window is the incoming bit (forced to 0 while flushing) over the history.
    always_comb begin
        out_free   = !out_valid_q || out_ready;
        in_ready_c = (state_q == S_DATA) && out_free && !rst;
        win_bit    = (state_q == S_DATA) ? in_bit : 1'b0;
        win        = {win_bit, sr_q};
        c0         = ^(win & G0);
        c1         = ^(win & G1);
        load       = (state_q == S_DATA) ? (in_valid && in_ready_c) : out_free;
    end

    // NOTE: every target is given its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        dcnt_d      = dcnt_q;
        tcnt_d      = tcnt_q;
        out_bits_d  = out_bits_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (load) begin
            out_bits_d  = {c0, c1};
            out_valid_d = 1'b1;
            sr_d        = win[K-1:1];
            out_last_d  = (state_q == S_TAIL) && (tcnt_q == TCNT_LAST);

            case (state_q)
                S_DATA: begin
                    if (dcnt_q == DCNT_LAST) begin
                        dcnt_d  = '0;
                        state_d = S_TAIL;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
                S_TAIL: begin
                    if (tcnt_q == TCNT_LAST) begin
                        tcnt_d  = '0;
                        state_d = S_DATA;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
                default: state_d = S_DATA;
            endcase
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_DATA;
            sr_q        <= '0;
            dcnt_q      <= '0;
            tcnt_q      <= '0;
            out_bits_q  <= 2'b00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            dcnt_q      <= dcnt_d;
            tcnt_q      <= tcnt_d;
            out_bits_q  <= out_bits_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_bits  = out_bits_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed self-checking bench for conv_encoder: (7,5) K=3 frames of 4 bits, plus a K=7 impulse frame.
// Inputs change and outputs are sampled around the falling edge.
module tb_conv_encoder;

    logic       clk;
    logic       rst;
    logic       in_bit, in_valid, in_ready;
    logic [1:0] out_bits;
    logic       out_valid, out_ready, out_last;

    logic       in_bit7, in_valid7, in_ready7;
    logic [1:0] out_bits7;
    logic       out_valid7, out_ready7, out_last7;

    int checks   = 0;
    int failures = 0;

    logic       in_q[$];
    logic [1:0] exp_w[$];
    logic       exp_l[$];
    int         t_stall;
    int         t_lat;

    conv_encoder #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(4)) dut (
        .clk(clk), .rst(rst),
        .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
        .out_bits(out_bits), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    conv_encoder #(.K(7), .G0(7'b1111001), .G1(7'b1011011), .FRAME_LEN(1)) dut7 (
        .clk(clk), .rst(rst),
        .in_bit(in_bit7), .in_valid(in_valid7), .in_ready(in_ready7),
        .out_bits(out_bits7), .out_valid(out_valid7), .out_ready(out_ready7), .out_last(out_last7)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Streams in_q into the K=3 encoder and scores every transferred word against exp_w/exp_l.
    // rdy_mode 0 holds out_ready high; rdy_mode 1 repeats the pattern 1,0,0,1.
    // Entered and left on a falling edge.
    task automatic run_stream(input string tag, input int rdy_mode, input int budget);
        int         bidx, oidx, cyc, first_acc, first_val;
        logic       held, hold_l;
        logic [1:0] hold_w;
        bidx = 0; oidx = 0; cyc = 0;
        first_acc = -1; first_val = -1;
        held = 1'b0; hold_w = 2'b00; hold_l = 1'b0;
        t_stall = 0;
        while (oidx < exp_w.size() && cyc < budget) begin
            out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            in_valid  = (bidx < in_q.size());
            in_bit    = in_valid ? in_q[bidx] : 1'b0;
            #1;
            if (held) begin
                check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_stall_bits"},  32'(out_bits),  32'(hold_w));
                check({tag, "_stall_last"},  32'(out_last),  32'(hold_l));
            end
            held   = out_valid && !out_ready;
            hold_w = out_bits;
            hold_l = out_last;
            if (!in_ready) t_stall++;
            if (out_valid && first_val < 0) first_val = cyc;
            if (out_valid && out_ready) begin
                check($sformatf("%s_word%0d", tag, oidx), 32'(out_bits), 32'(exp_w[oidx]));
                check($sformatf("%s_last%0d", tag, oidx), 32'(out_last), 32'(exp_l[oidx]));
                oidx++;
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                bidx++;
            end
            cyc++;
            @(negedge clk);
        end
        check({tag, "_word_count"}, 32'(oidx), 32'(exp_w.size()));
        t_lat = first_val - first_acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [6:0] lfsr;
        logic       u[6];
        logic [2:0] g0, g1;
        logic [6:0] g0v, g1v;
        logic       c0, c1;

        rst = 1'b1;
        in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_bit7 = 1'b0; in_valid7 = 1'b0; out_ready7 = 1'b1;

        // Reset values while rst is still asserted.
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bits",  32'(out_bits),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_in_ready7", 32'(in_ready7), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic frame, no backpressure.
        in_q  = {1'b1, 1'b0, 1'b1, 1'b1};
        exp_w = {2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        exp_l = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run_stream("basic", 0, 40);
        check("basic_tail_stalls", 32'(t_stall), 32'd2);
        check("basic_latency",     32'(t_lat),   32'd1);

        // Same frame under out_ready backpressure.
        @(negedge clk);
        run_stream("bp", 1, 80);

        // Three back-to-back frames from a PN7 source, scored against a convolution model
        // that restarts from the zero state at every frame.
        @(negedge clk);
        g0 = 3'b111;
        g1 = 3'b101;
        lfsr = 7'h5A;
        in_q.delete(); exp_w.delete(); exp_l.delete();
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 4; n++) begin
                u[n] = lfsr[6];
                in_q.push_back(lfsr[6]);
                lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            end
            u[4] = 1'b0;
            u[5] = 1'b0;
            for (int n = 0; n < 6; n++) begin
                c0 = 1'b0;
                c1 = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    if (n - j >= 0) begin
                        c0 = c0 ^ (u[n-j] & g0[2-j]);
                        c1 = c1 ^ (u[n-j] & g1[2-j]);
                    end
                end
                exp_w.push_back({c0, c1});
                exp_l.push_back(n == 5);
            end
        end
        run_stream("pn", 0, 60);

        // Reset after the second word of a frame, then a fresh frame of ones.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        @(negedge clk);
        in_bit = 1'b0;
        @(negedge clk);
        #1;
        check("mid_second_word", 32'(out_bits), 32'(2'b10));
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_bits",  32'(out_bits),  32'd0);
        check("mid_rst_out_last",  32'(out_last),  32'd0);
        rst = 1'b0;
        #1;
        check("mid_post_rst_in_ready", 32'(in_ready), 32'd1);
        in_q  = {1'b1, 1'b1, 1'b1, 1'b1};
        exp_w = {2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11};
        exp_l = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run_stream("restart", 0, 40);
        check("restart_latency", 32'(t_lat), 32'd1);

        // K=7, FRAME_LEN=1 impulse: the words walk the generator columns from the top tap down.
        @(negedge clk);
        g0v = 7'b1111001;
        g1v = 7'b1011011;
        in_valid7 = 1'b1;
        in_bit7   = 1'b1;
        #1;
        check("k7_in_ready_idle", 32'(in_ready7), 32'd1);
        @(negedge clk);
        in_valid7 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            check($sformatf("k7_valid%0d", k),    32'(out_valid7), 32'd1);
            check($sformatf("k7_word%0d", k),     32'(out_bits7),  32'({g0v[7-k], g1v[7-k]}));
            check($sformatf("k7_last%0d", k),     32'(out_last7),  32'(k == 7));
            check($sformatf("k7_in_ready%0d", k), 32'(in_ready7),  32'(k == 7));
            @(negedge clk);
        end
        #1;
        check("k7_drained", 32'(out_valid7), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
